// File: rtl/load_store_unit_if.sv
// Request, data-bus and register-file writeback signals of the load/store unit.
// slave is the unit's own view; master is the surrounding pipeline/bus view.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [2:0]  wb_we;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;

    logic        misaligned;
    logic        bus_err;

    modport slave (
        input  req_valid, req_store, req_op, req_addr, req_wdata, req_rd,
        input  mem_ack, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output wb_we, wb_a, wb_d,
        output misaligned, bus_err
    );

    modport master (
        output req_valid, req_store, req_op, req_addr, req_wdata, req_rd,
        output mem_ack, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  wb_we, wb_a, wb_d,
        input  misaligned, bus_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, req/ack data bus, load writeback; mem_req at T+1, WB at T+2.
// Backpressure: req_ready is low for the whole BUS/WB occupancy; bus timeout aborts with bus_err.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave lsu
);
    typedef enum logic [1:0] {IDLE, BUS, WB} state_t;

    typedef struct packed {
        logic        store;
        logic [2:0]  op;
        logic [1:0]  off;
        logic [29:0] word;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } hdr_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    hdr_t        hdr;
    logic [15:0] cnt;
    logic [4:0]  wb_a_q;
    logic [31:0] wb_d_q;
    logic        misaligned_q;
    logic        bus_err_q;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        legal;
    logic        bad_align;
    logic        accept;
    logic        start;
    logic        timeout;
    logic        in_bus;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    always_comb begin
        is_byte   = (lsu.req_op == 3'b001) || (lsu.req_op == 3'b010);
        is_half   = (lsu.req_op == 3'b011) || (lsu.req_op == 3'b100);
        is_word   = (lsu.req_op == 3'b101);
        legal     = is_byte || is_half || is_word;
        bad_align = (is_half && lsu.req_addr[0]) ||
                    (is_word && (lsu.req_addr[1:0] != 2'b00));
        accept    = (state == IDLE) && lsu.req_valid;
        start     = accept && legal && !bad_align;
        in_bus    = (state == BUS);
        timeout   = in_bus && !lsu.mem_ack && (cnt == CNT_LAST);

        // Store data is replicated to every lane so the slave picks it up under mem_be
        be_new    = 4'b1111;
        wdata_new = lsu.req_wdata;
        if (is_byte) begin
            be_new    = 4'b0001 << lsu.req_addr[1:0];
            wdata_new = {4{lsu.req_wdata[7:0]}};
        end else if (is_half) begin
            be_new    = 4'b0011 << lsu.req_addr[1:0];
            wdata_new = {2{lsu.req_wdata[15:0]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (lsu.mem_ack) begin
                    state_nxt = hdr.store ? IDLE : WB;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr          <= '0;
            cnt          <= '0;
            wb_a_q       <= '0;
            wb_d_q       <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            misaligned_q <= accept && legal && bad_align;
            bus_err_q    <= timeout;
            if (start) begin
                hdr <= '{store: lsu.req_store,
                         op:    lsu.req_op,
                         off:   lsu.req_addr[1:0],
                         word:  lsu.req_addr[31:2],
                         be:    be_new,
                         wdata: wdata_new,
                         rd:    lsu.req_rd};
                cnt <= '0;
            end else if (in_bus && !lsu.mem_ack) begin
                cnt <= cnt + 16'd1;
            end
            // Right-justify the addressed lane; upper bytes are left for the register file
            if (in_bus && lsu.mem_ack && !hdr.store) begin
                wb_a_q <= hdr.rd;
                wb_d_q <= lsu.mem_rdata >> {hdr.off, 3'b000};
            end
        end
    end

    assign lsu.req_ready  = (state == IDLE);
    assign lsu.mem_req    = in_bus;
    assign lsu.mem_we     = in_bus && hdr.store;
    assign lsu.mem_addr   = in_bus ? {hdr.word, 2'b00} : 32'h0;
    assign lsu.mem_wdata  = in_bus ? hdr.wdata : 32'h0;
    assign lsu.mem_be     = in_bus ? hdr.be : 4'h0;
    assign lsu.wb_we      = (state == WB) ? hdr.op : 3'b000;
    assign lsu.wb_a       = wb_a_q;
    assign lsu.wb_d       = wb_d_q;
    assign lsu.misaligned = misaligned_q;
    assign lsu.bus_err    = bus_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, random transactions vs a reference model,
// and hand-written reset sequences.
module tb_load_store_unit;
    localparam int TO = 4;

    logic clk;
    logic rst_n;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        store;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [7:0]  delay;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic        bus;
        logic        we;
        logic [7:0]  req_cycles;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic        wb;
        logic [2:0]  wb_we;
        logic [4:0]  wb_a;
        logic [31:0] wb_d;
        logic        mis;
        logic        err;
        logic        ready_after;
    } exp_t;

    typedef struct packed {
        logic [7:0]  req_cycles;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic        stable;
        logic [7:0]  wb_cnt;
        logic [2:0]  wb_we;
        logic [4:0]  wb_a;
        logic [31:0] wb_d;
        logic [7:0]  mis_cnt;
        logic [7:0]  err_cnt;
        logic        ready_after;
    } obs_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic in_t mk_in(input logic st, input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [4:0] rd,
                                  input logic [7:0] dly, input logic [31:0] rdata);
        in_t v;
        v.store = st; v.op = op; v.addr = addr; v.wdata = wd;
        v.rd = rd; v.delay = dly; v.rdata = rdata;
        return v;
    endfunction

    function automatic exp_t mk_bus(input logic we, input logic [7:0] cyc, input logic [31:0] maddr,
                                    input logic [3:0] be, input logic [31:0] mwd, input logic wb,
                                    input logic [2:0] wb_we, input logic [4:0] wb_a,
                                    input logic [31:0] wb_d, input logic err, input logic rdy);
        exp_t e;
        e = '0;
        e.bus = 1'b1; e.we = we; e.req_cycles = cyc; e.maddr = maddr; e.be = be;
        e.mwdata = mwd; e.wb = wb; e.wb_we = wb_we; e.wb_a = wb_a; e.wb_d = wb_d;
        e.err = err; e.ready_after = rdy;
        return e;
    endfunction

    function automatic exp_t mk_nobus(input logic mis);
        exp_t e;
        e = '0;
        e.mis = mis;
        return e;
    endfunction

    // Reference: access size in bytes, natural alignment, lane replication, shift by byte offset.
    function automatic exp_t model(input in_t v);
        exp_t e;
        int   n;
        int   off;
        e   = '0;
        off = int'(v.addr % 32'd4);
        case (v.op)
            3'd1, 3'd2: n = 1;
            3'd3, 3'd4: n = 2;
            3'd5:       n = 4;
            default:    n = 0;
        endcase
        if (n == 0) return e;
        if ((off % n) != 0) begin
            e.mis = 1'b1;
            return e;
        end
        e.bus   = 1'b1;
        e.we    = v.store;
        e.maddr = v.addr - 32'(off);
        e.be    = 4'(((1 << n) - 1) << off);
        for (int b = 0; b < 4; b++) e.mwdata[8*b +: 8] = v.wdata[8*(b % n) +: 8];
        if (int'(v.delay) >= TO) begin
            e.req_cycles  = 8'(TO);
            e.err         = 1'b1;
            e.ready_after = 1'b1;
        end else begin
            e.req_cycles  = v.delay + 8'd1;
            e.ready_after = v.store;
            if (!v.store) begin
                e.wb    = 1'b1;
                e.wb_we = v.op;
                e.wb_a  = v.rd;
                e.wb_d  = v.rdata >> (8 * off);
            end
        end
        return e;
    endfunction

    // Offers one request, then plays the bus slave for a fixed window and records what it saw.
    task automatic run_txn(input in_t v, output obs_t o);
        logic prev_req;
        o        = '0;
        o.stable = 1'b1;
        prev_req = 1'b0;
        bus.req_store = v.store;
        bus.req_op    = v.op;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_rd    = v.rd;
        bus.req_valid = 1'b1;
        bus.mem_ack   = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus.mem_req) begin
                if (o.req_cycles == 0) begin
                    o.we = bus.mem_we; o.maddr = bus.mem_addr;
                    o.be = bus.mem_be; o.mwdata = bus.mem_wdata;
                end else if (o.we !== bus.mem_we || o.maddr !== bus.mem_addr ||
                             o.be !== bus.mem_be || o.mwdata !== bus.mem_wdata) begin
                    o.stable = 1'b0;
                end
                bus.mem_ack   = (o.req_cycles == v.delay);
                bus.mem_rdata = bus.mem_ack ? v.rdata : $urandom;
                o.req_cycles++;
            end else begin
                if (prev_req) o.ready_after = bus.req_ready;
                bus.mem_ack   = 1'($urandom % 2);
                bus.mem_rdata = $urandom;
            end
            prev_req = bus.mem_req;
            if (bus.wb_we != 3'b000) begin
                o.wb_cnt++;
                o.wb_we = bus.wb_we; o.wb_a = bus.wb_a; o.wb_d = bus.wb_d;
            end
            if (bus.misaligned) o.mis_cnt++;
            if (bus.bus_err)    o.err_cnt++;
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic compare(input string tag, input obs_t o, input exp_t e);
        chk($sformatf("%s.req_cycles", tag), 32'(o.req_cycles), 32'(e.req_cycles));
        chk($sformatf("%s.misaligned", tag), 32'(o.mis_cnt), 32'(e.mis));
        chk($sformatf("%s.bus_err", tag), 32'(o.err_cnt), 32'(e.err));
        chk($sformatf("%s.wb_count", tag), 32'(o.wb_cnt), 32'(e.wb));
        if (e.bus) begin
            chk($sformatf("%s.mem_we", tag), 32'(o.we), 32'(e.we));
            chk($sformatf("%s.mem_addr", tag), o.maddr, e.maddr);
            chk($sformatf("%s.mem_be", tag), 32'(o.be), 32'(e.be));
            chk($sformatf("%s.stable", tag), 32'(o.stable), 32'd1);
            chk($sformatf("%s.ready_after", tag), 32'(o.ready_after), 32'(e.ready_after));
            if (e.we) chk($sformatf("%s.mem_wdata", tag), o.mwdata, e.mwdata);
        end
        if (e.wb) begin
            chk($sformatf("%s.wb_we", tag), 32'(o.wb_we), 32'(e.wb_we));
            chk($sformatf("%s.wb_a", tag), 32'(o.wb_a), 32'(e.wb_a));
            chk($sformatf("%s.wb_d", tag), o.wb_d, e.wb_d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        obs_t o;
        in_t  r;
        int   wbs;
        int   reqs;

        vecs[0]  = '{i: mk_in(0, 3'd5, 32'h100, 32'h0, 5'd5, 8'd1, 32'hDEADBEEF),
                     e: mk_bus(0, 8'd2, 32'h100, 4'hF, 32'h0, 1, 3'd5, 5'd5, 32'hDEADBEEF, 0, 0)};
        vecs[1]  = '{i: mk_in(0, 3'd2, 32'h103, 32'h0, 5'd7, 8'd0, 32'h80112233),
                     e: mk_bus(0, 8'd1, 32'h100, 4'h8, 32'h0, 1, 3'd2, 5'd7, 32'h00000080, 0, 0)};
        vecs[2]  = '{i: mk_in(0, 3'd4, 32'h102, 32'h0, 5'd9, 8'd2, 32'hBEEF1234),
                     e: mk_bus(0, 8'd3, 32'h100, 4'hC, 32'h0, 1, 3'd4, 5'd9, 32'h0000BEEF, 0, 0)};
        vecs[3]  = '{i: mk_in(1, 3'd3, 32'h202, 32'h1234ABCD, 5'd3, 8'd0, 32'h0),
                     e: mk_bus(1, 8'd1, 32'h200, 4'hC, 32'hABCDABCD, 0, 3'd0, 5'd0, 32'h0, 0, 1)};
        vecs[4]  = '{i: mk_in(0, 3'd5, 32'h101, 32'h0, 5'd4, 8'd0, 32'h0), e: mk_nobus(1)};
        vecs[5]  = '{i: mk_in(1, 3'd5, 32'h102, 32'h11223344, 5'd0, 8'd0, 32'h0), e: mk_nobus(1)};
        vecs[6]  = '{i: mk_in(0, 3'd5, 32'h104, 32'h0, 5'd6, 8'd9, 32'h12345678),
                     e: mk_bus(0, 8'd4, 32'h104, 4'hF, 32'h0, 0, 3'd0, 5'd0, 32'h0, 1, 1)};
        vecs[7]  = '{i: mk_in(0, 3'd0, 32'h100, 32'h0, 5'd1, 8'd0, 32'h0), e: mk_nobus(0)};
        vecs[8]  = '{i: mk_in(1, 3'd1, 32'h30001, 32'h55AA, 5'd0, 8'd3, 32'h0),
                     e: mk_bus(1, 8'd4, 32'h30000, 4'h2, 32'hAAAAAAAA, 0, 3'd0, 5'd0, 32'h0, 0, 1)};
        vecs[9]  = '{i: mk_in(0, 3'd1, 32'h101, 32'h0, 5'd0, 8'd0, 32'hA1B2C3D4),
                     e: mk_bus(0, 8'd1, 32'h100, 4'h2, 32'h0, 1, 3'd1, 5'd0, 32'h00A1B2C3, 0, 0)};
        vecs[10] = '{i: mk_in(0, 3'd3, 32'h100, 32'h0, 5'd31, 8'd1, 32'hFFFF8001),
                     e: mk_bus(0, 8'd2, 32'h100, 4'h3, 32'h0, 1, 3'd3, 5'd31, 32'hFFFF8001, 0, 0)};
        vecs[11] = '{i: mk_in(1, 3'd7, 32'h200, 32'h0, 5'd2, 8'd0, 32'h0), e: mk_nobus(0)};
        vecs[12] = '{i: mk_in(1, 3'd5, 32'h40C, 32'hCAFEF00D, 5'd0, 8'd1, 32'h0),
                     e: mk_bus(1, 8'd2, 32'h40C, 4'hF, 32'hCAFEF00D, 0, 3'd0, 5'd0, 32'h0, 0, 1)};

        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_op = 3'd0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'd0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        chk("reset.req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset.mem_req", 32'(bus.mem_req), 32'd0);
        chk("reset.mem_be", 32'(bus.mem_be), 32'd0);
        chk("reset.wb_we", 32'(bus.wb_we), 32'd0);
        chk("reset.wb_d", bus.wb_d, 32'd0);
        chk("reset.misaligned", 32'(bus.misaligned), 32'd0);
        chk("reset.bus_err", 32'(bus.bus_err), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 13; k++) begin
            chk($sformatf("vec%0d.idle_ready", k), 32'(bus.req_ready), 32'd1);
            run_txn(vecs[k].i, o);
            compare($sformatf("vec%0d", k), o, vecs[k].e);
        end

        for (int k = 0; k < 200; k++) begin
            r = mk_in(1'($urandom % 2), 3'($urandom_range(0, 7)), $urandom, $urandom,
                      5'($urandom), 8'($urandom_range(0, 5)), $urandom);
            run_txn(r, o);
            compare($sformatf("rnd%0d", k), o, model(r));
        end

        // Asynchronous reset in the middle of a load: bus drops at once, no writeback follows.
        bus.req_store = 1'b0; bus.req_op = 3'd5; bus.req_addr = 32'h180;
        bus.req_rd = 5'd12; bus.req_valid = 1'b1; bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst.pre_mem_req", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.mem_req", 32'(bus.mem_req), 32'd0);
        chk("midrst.req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5A5A5A5A;
        @(posedge clk); #3 rst_n = 1'b1;
        wbs  = 0;
        reqs = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.wb_we != 3'b000) wbs++;
            if (bus.mem_req) reqs++;
        end
        bus.mem_ack = 1'b0;
        chk("midrst.no_wb", 32'(wbs), 32'd0);
        chk("midrst.no_req", 32'(reqs), 32'd0);
        chk("midrst.ready", 32'(bus.req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
